// File: rtl/sid_cmd_player.sv
// Streaming SID register-write player: FIFO-buffered {addr,data} commands replayed at one write per ce_1m tick.
// Optional SID_CMD_LONG_DELAY_EN: 16-bit wait counter and address 5'h1e as a data*256 long delay.
module sid_cmd_player #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [4:0] DELAY_CMD  = 5'h1f
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_1m,
    input  logic                  cmd_valid,
    input  logic [4:0]            cmd_addr,
    input  logic [7:0]            cmd_data,
    output logic                  cmd_ready,
    output logic                  sid_we,
    output logic [4:0]            sid_addr,
    output logic [7:0]            sid_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  idle
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
`ifdef SID_CMD_LONG_DELAY_EN
    localparam int         WAIT_W         = 16;
    localparam logic [4:0] LONG_DELAY_CMD = 5'h1e;
`else
    localparam int         WAIT_W         = 8;
`endif

    logic [12:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic [WAIT_W-1:0]     wait_r;
    logic                  sid_we_r;
    logic [4:0]            sid_addr_r;
    logic [7:0]            sid_data_r;

    logic                  push_s;
    logic                  pop_s;
    logic [4:0]            head_addr_s;
    logic [7:0]            head_data_s;
    logic [WAIT_W-1:0]     wait_nxt_s;
    logic                  we_nxt_s;
    logic [4:0]            addr_nxt_s;
    logic [7:0]            data_nxt_s;

    assign cmd_ready   = (level_r != FULL_LVL);
    assign push_s      = cmd_valid && cmd_ready;
    assign head_addr_s = mem_r[rd_ptr_r][12:8];
    assign head_data_s = mem_r[rd_ptr_r][7:0];

    // Replay decision: only ce_1m edges advance; pops look at the registered level so there is no bypass.
    always_comb begin
        pop_s      = 1'b0;
        wait_nxt_s = wait_r;
        we_nxt_s   = sid_we_r;
        addr_nxt_s = sid_addr_r;
        data_nxt_s = sid_data_r;
        if (ce_1m) begin
            if (wait_r != '0) begin
                wait_nxt_s = wait_r - WAIT_W'(1);
                we_nxt_s   = 1'b0;
            end else if (level_r == '0) begin
                we_nxt_s   = 1'b0;
            end else if (head_addr_s == DELAY_CMD) begin
                pop_s      = 1'b1;
                wait_nxt_s = WAIT_W'(head_data_s);
                we_nxt_s   = 1'b0;
`ifdef SID_CMD_LONG_DELAY_EN
            end else if (head_addr_s == LONG_DELAY_CMD) begin
                pop_s      = 1'b1;
                wait_nxt_s = {head_data_s, 8'h00};
                we_nxt_s   = 1'b0;
`endif
            end else begin
                pop_s      = 1'b1;
                addr_nxt_s = head_addr_s;
                data_nxt_s = head_data_s;
                we_nxt_s   = 1'b1;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_addr, cmd_data};
        end
    end

    // Pointers, occupancy, wait counter and SID write-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            wait_r     <= '0;
            sid_we_r   <= 1'b0;
            sid_addr_r <= 5'h00;
            sid_data_r <= 8'h00;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            wait_r     <= wait_nxt_s;
            sid_we_r   <= we_nxt_s;
            sid_addr_r <= addr_nxt_s;
            sid_data_r <= data_nxt_s;
        end
    end

    assign sid_we   = sid_we_r;
    assign sid_addr = sid_addr_r;
    assign sid_data = sid_data_r;
    assign level    = level_r;
    assign idle     = (level_r == '0) && (wait_r == '0);

endmodule
